pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_if.sv | 36 +++
 rtl/pipe_stage_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data,
// downstream valid/ready/data, squash and fill level.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             flush;
  logic [1:0]       occupancy;

  modport master (
    output in_valid,
    output din,
    output out_ready,
    output flush,
    input  in_ready,
    input  out_valid,
    input  dout,
    input  occupancy
  );

  modport slave (
    input  in_valid,
    input  din,
    input  out_ready,
    input  flush,
    output in_ready,
    output out_valid,
    output dout,
    output occupancy
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready, flush and an
// optional skid entry enabled by `PIPE_STAGE_REG_SKID_EN.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic            clk,
  input  logic            rst,
  pipe_stage_reg_if.slave bus
);

`ifdef PIPE_STAGE_REG_SKID_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;
`else
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             in_fire;
  logic             out_fire;

  assign bus.out_valid = (state_q != EMPTY);
  assign bus.dout      = main_q;
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;

  // Ready comes from state only, so out_ready never reaches in_ready.
  assign bus.in_ready  = (state_q != SKID) & ~rst;
  assign bus.occupancy = {state_q == SKID, state_q == FULL};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = bus.din;
          state_d = FULL;
        end
      end
      FULL: begin
        unique case (1'b1)
          (in_fire & out_fire): begin
            main_d = bus.din;
          end
          (in_fire & ~out_fire): begin
            skid_d  = bus.din;
            state_d = SKID;
          end
          (~in_fire & out_fire): begin
            state_d = EMPTY;
          end
          default: ;
        endcase
      end
      SKID: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash drops everything; data regs keep their contents.
    if (bus.flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
`else
  // Single entry: a draining word frees the slot in the same cycle.
  assign bus.in_ready  = (~bus.out_valid | bus.out_ready) & ~rst;
  assign bus.occupancy = {1'b0, state_q == FULL};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = bus.din;
          state_d = FULL;
        end
      end
      FULL: begin
        unique case (1'b1)
          in_fire: begin
            main_d = bus.din;
          end
          (~in_fire & out_fire): begin
            state_d = EMPTY;
          end
          default: ;
        endcase
      end
    endcase
    if (bus.flush) begin
      state_d = EMPTY;
      main_d  = main_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg: a word queue is the reference,
// plus directed reset, streaming, stall and flush sequences.
module tb_pipe_stage_reg;
  localparam int unsigned      W  = 32;
  localparam logic [W-1:0]     RV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] last_out;

  pipe_stage_reg_if #(.WIDTH(W)) bus ();

  pipe_stage_reg #(
    .WIDTH(W),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Capacity rule: two entries with skid, else one entry that can
  // be replaced while it is being drained.
  function automatic logic exp_rdy(input logic ordy);
    if (rst) return 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || ordy;
`endif
  endfunction

  task automatic chk_out();
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("occupancy", bus.occupancy, q.size());
    if (q.size() != 0) chk("dout", bus.dout, q[0]);
  endtask

  // One cycle: drive after negedge, model the edge, check at negedge.
  task automatic step(input logic iv, input logic [W-1:0] d,
                      input logic ordy, input logic fl);
    logic er;
    logic inf;
    logic outf;
    bus.in_valid  = iv;
    bus.din       = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    er   = exp_rdy(ordy);
    chk("in_ready", bus.in_ready, er);
    outf = ordy && (q.size() != 0);
    inf  = iv && er;
    @(posedge clk);
    if (outf) last_out = q.pop_front();
    if (inf) q.push_back(d);
    if (fl) q.delete();
    @(negedge clk);
    chk_out();
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    last_out = '0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_dout", bus.dout, RV);
    chk("rst_occ", bus.occupancy, 2'd0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    chk("stream_last_out", last_out, 32'd3);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drain", last_out, 32'd4);

`ifdef PIPE_STAGE_REG_SKID_EN
    // Stall absorbs exactly one extra word
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    chk("stall_occ", bus.occupancy, 2'd2);
    step(1'b1, 32'hEE, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stall_first", last_out, 32'hA);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stall_second", last_out, 32'hB);

    // Flush while SKID with a concurrent input
    step(1'b1, 32'h1A, 1'b0, 1'b0);
    step(1'b1, 32'h1B, 1'b0, 1'b0);
`else
    step(1'b1, 32'h1A, 1'b0, 1'b0);
`endif
    step(1'b1, 32'hC, 1'b0, 1'b1);
    chk("flush_occ", bus.occupancy, 2'd0);
    chk("flush_valid", bus.out_valid, 1'b0);

    // Flush coincident with output fire
    last_out = '0;
    step(1'b1, 32'h5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("flush_fire_deliv", last_out, 32'h5);
    chk("flush_fire_empty", bus.out_valid, 1'b0);

    // Async reset mid-cycle while FULL, together with flush
    step(1'b1, 32'h77, 1'b0, 1'b0);
    idle_inputs();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    bus.flush = 1'b1;
    #1;
    q.delete();
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_dout", bus.dout, RV);
    chk("arst_occ", bus.occupancy, 2'd0);
    chk("arst_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst       = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("arst_release_rdy", bus.in_ready, 1'b1);
    @(negedge clk);

    // Random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, W'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
